// File: rtl/mac_pkg.sv
// Shared MAC definitions: framer state encoding and Ethernet framing/CRC constants.
package mac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } tx_state_e;

  localparam logic [7:0]  C_PREAMBLE     = 8'h55;
  localparam logic [7:0]  C_SFD          = 8'hD5;
  localparam logic [31:0] C_CRC_INIT     = 32'hFFFF_FFFF;
  localparam logic [31:0] C_CRC_POLY_REF = 32'hEDB8_8320;

endpackage

// File: rtl/crc32_d8.sv
// Combinational IEEE 802.3 CRC-32 step over one byte (reflected, LSB first).
module crc32_d8
  import mac_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  logic [31:0] c;

  always_comb begin
    c = i_crc ^ {24'h0, i_data};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ C_CRC_POLY_REF) : (c >> 1);
    o_crc = c;
  end

endmodule

// File: rtl/mac_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload, optional zero pad, FCS, IFG.
// Zero padding to P_MIN_LEN is built only when MAC_TX_PAD_EN is defined.
module mac_tx_framer
  import mac_pkg::*;
#(
  parameter int P_IFG = 12
`ifdef MAC_TX_PAD_EN
  , parameter int P_MIN_LEN = 60
`endif
) (
  input  logic       i_udp_stack_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_send_data,
  input  logic       i_send_valid,
  input  logic       i_send_last,
  output logic       o_send_ready,
  output logic [7:0] o_GMII_data,
  output logic       o_GMII_valid,
  output logic       o_busy,
  output logic       o_underrun
);

  tx_state_e   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] crc_q, crc_d;
  logic [7:0]  gmii_data_q, gmii_data_d;
  logic        gmii_valid_q, gmii_valid_d;
  logic        underrun_q, underrun_d;

  logic [7:0]  crc_in;
  logic [31:0] crc_nxt;
  logic [31:0] crc_inv;
  logic        accept;

  assign accept  = ((state_q == ST_SFD) || (state_q == ST_DATA)) && i_send_valid;
  assign crc_in  = (state_q == ST_PAD) ? 8'h00 : i_send_data;
  assign crc_inv = ~crc_q;

  crc32_d8 u_crc (
    .i_crc  (crc_q),
    .i_data (crc_in),
    .o_crc  (crc_nxt)
  );

`ifdef MAC_TX_PAD_EN
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [15:0] byte_inc;
  logic        short_frame;

  assign byte_inc    = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
  assign short_frame = (32'(byte_inc) < 32'(P_MIN_LEN));

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (state_q == ST_IDLE)
      byte_cnt_d = 16'd0;
    else if (accept || (state_q == ST_PAD))
      byte_cnt_d = byte_inc;
  end

  always_ff @(posedge i_udp_stack_clk) begin
    if (!i_rst_n) byte_cnt_q <= 16'd0;
    else          byte_cnt_q <= byte_cnt_d;
  end
`endif

  always_ff @(posedge i_udp_stack_clk) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (i_send_valid) state_d = ST_PREAMBLE;
      ST_PREAMBLE: if (cnt_q == 8'd6) state_d = ST_SFD;
      ST_SFD, ST_DATA: begin
        if (!i_send_valid)
          state_d = ST_IFG;
        else if (i_send_last)
`ifdef MAC_TX_PAD_EN
          state_d = short_frame ? ST_PAD : ST_FCS;
`else
          state_d = ST_FCS;
`endif
        else
          state_d = ST_DATA;
      end
`ifdef MAC_TX_PAD_EN
      ST_PAD:      if (!short_frame) state_d = ST_FCS;
`endif
      ST_FCS:      if (cnt_q == 8'd3) state_d = ST_IFG;
      ST_IFG:      if (cnt_q == 8'(P_IFG - 1)) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // GMII register is loaded with the byte for the state being entered, so the
  // preamble leaves one cycle after valid is sampled and data has one cycle of latency.
  always_comb begin
    gmii_data_d  = 8'h00;
    gmii_valid_d = 1'b0;
    underrun_d   = 1'b0;
    crc_d        = crc_q;
    cnt_d        = (state_d != state_q) ? 8'd0 : cnt_q + 8'd1;
    case (state_q)
      ST_IDLE: if (i_send_valid) begin
        gmii_data_d  = C_PREAMBLE;
        gmii_valid_d = 1'b1;
        crc_d        = C_CRC_INIT;
      end
      ST_PREAMBLE: begin
        gmii_data_d  = (cnt_q == 8'd6) ? C_SFD : C_PREAMBLE;
        gmii_valid_d = 1'b1;
      end
      ST_SFD, ST_DATA: begin
        if (i_send_valid) begin
          gmii_data_d  = i_send_data;
          gmii_valid_d = 1'b1;
          crc_d        = crc_nxt;
        end else begin
          underrun_d   = 1'b1;
        end
      end
      ST_PAD: begin
        gmii_valid_d = 1'b1;
        crc_d        = crc_nxt;
      end
      ST_FCS: begin
        gmii_data_d  = crc_inv[{cnt_q[1:0], 3'b000} +: 8];
        gmii_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_udp_stack_clk) begin
    if (!i_rst_n) begin
      cnt_q        <= 8'd0;
      crc_q        <= C_CRC_INIT;
      gmii_data_q  <= 8'h00;
      gmii_valid_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      crc_q        <= crc_d;
      gmii_data_q  <= gmii_data_d;
      gmii_valid_q <= gmii_valid_d;
      underrun_q   <= underrun_d;
    end
  end

  assign o_send_ready = (state_q == ST_SFD) || (state_q == ST_DATA);
  assign o_busy       = (state_q != ST_IDLE);
  assign o_GMII_data  = gmii_data_q;
  assign o_GMII_valid = gmii_valid_q;
  assign o_underrun   = underrun_q;

endmodule

// File: tb/tb_mac_tx_framer.sv
// Directed bench for mac_tx_framer; expectations adapt to MAC_TX_PAD_EN.
module tb_mac_tx_framer;

`ifdef MAC_TX_PAD_EN
  localparam int MIN_LEN = 60;
`else
  localparam int MIN_LEN = 0;
`endif
  localparam int IFG   = 12;
  localparam int RECN  = 8192;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] send_data;
  logic       send_valid, send_last;
  logic       send_ready;
  logic [7:0] gmii_data;
  logic       gmii_valid, busy, underrun;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] tx_buf  [0:255];
  logic       tx_last [0:255];

  logic [7:0] rec_d [0:RECN-1];
  logic       rec_v [0:RECN-1];
  logic       rec_r [0:RECN-1];
  logic       rec_b [0:RECN-1];
  logic       rec_u [0:RECN-1];
  int         cyc = 0;

  always #5 clk = ~clk;

  mac_tx_framer dut (
    .i_udp_stack_clk (clk),
    .i_rst_n         (rst_n),
    .i_send_data     (send_data),
    .i_send_valid    (send_valid),
    .i_send_last     (send_last),
    .o_send_ready    (send_ready),
    .o_GMII_data     (gmii_data),
    .o_GMII_valid    (gmii_valid),
    .o_busy          (busy),
    .o_underrun      (underrun)
  );

  always @(negedge clk) begin
    if (cyc < RECN) begin
      rec_d[cyc] <= gmii_data;
      rec_v[cyc] <= gmii_valid;
      rec_r[cyc] <= send_ready;
      rec_b[cyc] <= busy;
      rec_u[cyc] <= underrun;
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_ref(input int off, input int n, input int plen);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFF_FFFF;
    for (int k = 0; k < plen; k++) begin
      b = (k < n) ? tx_buf[off + k] : 8'h00;
      c = c ^ {24'h0, b};
      for (int j = 0; j < 8; j++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic drive(input int off, input int n, input int drop_at, output int t0);
    int  idx, guard;
    logic acc;
    t0 = cyc;
    idx = 0; guard = 0;
    send_valid = 1'b1;
    send_data  = tx_buf[off];
    send_last  = tx_last[off];
    while (idx < n && guard < 3000) begin
      @(negedge clk);
      acc = send_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx == drop_at) break;
        if (idx < n) begin
          send_data = tx_buf[off + idx];
          send_last = tx_last[off + idx];
        end
      end
      guard++;
    end
    send_valid = 1'b0; send_last = 1'b0; send_data = 8'h00;
    if (guard >= 3000) chk("drive_timeout", 32'(guard), 32'(0));
  endtask

  task automatic wait_idle();
    int g;
    for (g = 0; g < 2000; g++) begin
      @(posedge clk); #2;
      if (!busy) break;
    end
    if (g >= 2000) chk("idle_timeout", 32'(g), 32'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input int from, input int t0,
                             input int off, input int n, output int fin);
    int st, len, plen, e_pre, e_pay, e_pad;
    logic [31:0] fcs;
    st = -1;
    for (int i = from; i < cyc && i < RECN; i++)
      if (rec_v[i] && st < 0) st = i;
    if (st < 0) begin
      chk({tag, "_found"}, 32'(0), 32'(1));
      fin = from;
      return;
    end
    if (t0 >= 0) chk({tag, "_start"}, 32'(st), 32'(t0 + 1));
    len = 0;
    while (st + len < RECN && rec_v[st + len]) len++;
    fin  = st + len;
    plen = (n > MIN_LEN) ? n : MIN_LEN;
    chk({tag, "_len"}, 32'(len), 32'(8 + plen + 4));
    e_pre = 0; e_pay = 0; e_pad = 0;
    for (int i = 0; i < 7; i++) if (rec_d[st + i] !== 8'h55) e_pre++;
    chk({tag, "_preamble"}, 32'(e_pre), 32'(0));
    chk({tag, "_sfd"}, 32'(rec_d[st + 7]), 32'h0000_00D5);
    for (int i = 0; i < n; i++) if (rec_d[st + 8 + i] !== tx_buf[off + i]) e_pay++;
    chk({tag, "_payload"}, 32'(e_pay), 32'(0));
    for (int i = n; i < plen; i++) if (rec_d[st + 8 + i] !== 8'h00) e_pad++;
    chk({tag, "_pad"}, 32'(e_pad), 32'(0));
    fcs = {rec_d[st + 8 + plen + 3], rec_d[st + 8 + plen + 2],
           rec_d[st + 8 + plen + 1], rec_d[st + 8 + plen]};
    chk({tag, "_fcs"}, fcs, crc_ref(off, n, plen));
  endtask

  initial begin
    int from, t0, fin, fin2, gap, rdy, ucnt, uidx, bcnt, nv, plen, g;
    rst_n = 1'b0; send_valid = 1'b0; send_last = 1'b0; send_data = 8'h00;
    for (int i = 0; i < 256; i++) begin tx_buf[i] = 8'h00; tx_last[i] = 1'b0; end

    repeat (3) @(posedge clk); #2;
    chk("rst_gmii_valid", 32'(gmii_valid), 32'(0));
    chk("rst_gmii_data",  32'(gmii_data),  32'(0));
    chk("rst_ready",      32'(send_ready), 32'(0));
    chk("rst_busy",       32'(busy),       32'(0));
    chk("rst_underrun",   32'(underrun),   32'(0));
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // "123456789"
    for (int i = 0; i < 9; i++) tx_buf[i] = 8'h31 + 8'(i);
    tx_last[8] = 1'b1;
    from = cyc;
    drive(0, 9, 0, t0);
    wait_idle();
    check_frame("ascii", from, t0, 0, 9, fin);
`ifndef MAC_TX_PAD_EN
    chk("ascii_fcs_const", {rec_d[fin-1], rec_d[fin-2], rec_d[fin-3], rec_d[fin-4]},
        32'hCBF4_3926);
`endif

    // two 64-byte frames, valid held across the gap
    for (int i = 0; i < 128; i++) begin
      tx_buf[i] = 8'(i * 7 + 3); tx_last[i] = (i == 63) || (i == 127);
    end
    from = cyc;
    drive(0, 128, 0, t0);
    wait_idle();
    check_frame("b2b_f1", from, t0, 0, 64, fin);
    gap = 0; rdy = 0;
    while (fin + gap < RECN && !rec_v[fin + gap] && gap < 100) begin
      if (rec_r[fin + gap]) rdy++;
      gap++;
    end
    chk("b2b_gap", 32'(gap), 32'(IFG));
    chk("b2b_gap_ready", 32'(rdy), 32'(0));
    check_frame("b2b_f2", fin, -1, 64, 64, fin2);

    // underrun after 10 bytes
    for (int i = 0; i < 20; i++) begin tx_buf[i] = 8'hA0 + 8'(i); tx_last[i] = 1'b0; end
    from = cyc;
    drive(0, 20, 10, t0);
    wait_idle();
    nv = 0; ucnt = 0; uidx = -1; bcnt = 0; fin = -1;
    for (int i = from; i < cyc; i++) begin
      if (rec_v[i]) nv++;
      if (rec_v[i] && !rec_v[i + 1] && fin < 0) fin = i + 1;
      if (rec_u[i]) begin ucnt++; uidx = i; end
      if (rec_b[i]) bcnt++;
    end
    chk("urun_txen_cycles", 32'(nv), 32'(18));
    chk("urun_last_byte", 32'(rec_d[fin - 1]), 32'h0000_00A9);
    chk("urun_pulses", 32'(ucnt), 32'(1));
    chk("urun_pulse_cycle", 32'(uidx), 32'(fin));
    chk("urun_busy_cycles", 32'(bcnt), 32'(18 + IFG));

    // reset during second FCS byte, then immediate new frame
    for (int i = 0; i < 9; i++) begin tx_buf[i] = 8'h31 + 8'(i); tx_last[i] = (i == 8); end
    plen = (9 > MIN_LEN) ? 9 : MIN_LEN;
    from = cyc;
    drive(0, 9, 0, t0);
    for (g = 0; g < 500; g++) begin
      @(posedge clk); #2;
      nv = 0;
      for (int i = from; i < cyc; i++) if (rec_v[i]) nv++;
      if (nv + int'(gmii_valid) == 8 + plen + 2) break;
    end
    if (g >= 500) chk("rst_wait_timeout", 32'(g), 32'(0));
    chk("rst_pre_fcs2", 32'(gmii_data), 32'(crc_ref(0, 9, plen) >> 8) & 32'hFF);
    rst_n = 1'b0;
    @(posedge clk); #2;
    chk("mrst_gmii_valid", 32'(gmii_valid), 32'(0));
    chk("mrst_gmii_data",  32'(gmii_data),  32'(0));
    chk("mrst_ready",      32'(send_ready), 32'(0));
    chk("mrst_busy",       32'(busy),       32'(0));
    chk("mrst_underrun",   32'(underrun),   32'(0));
    rst_n = 1'b1;
    tx_buf[0] = 8'h5A;
    for (int i = 1; i < 9; i++) tx_buf[i] = 8'h10 + 8'(i);
    fin = cyc;
    drive(0, 9, 0, t0);
    wait_idle();
    nv = 0;
    for (int i = from; i < fin; i++) if (rec_v[i]) nv++;
    chk("mrst_truncated", 32'(nv), 32'(8 + plen + 2));
    check_frame("after_rst", fin, t0, 0, 9, fin2);

    // single-byte frame: last on the SFD-cycle byte
    tx_buf[0] = 8'hA5; tx_last[0] = 1'b1;
    from = cyc;
    drive(0, 1, 0, t0);
    wait_idle();
    check_frame("one_byte", from, t0, 0, 1, fin);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1);
  end

endmodule
